picxo_lock_sequencer: RTL
=========================

// Module: picxo_lock_sequencer
// PURPOSE
// Startup and supervision controller for the PICXO-based TX phase aligner.
// - Holds PICXO in reset until the GT TX path is up, then releases it and waits for the loop to settle.
// - Declares lock once the phase error stays inside a window for a run of consecutive DSP updates.
// - Re-resets PICXO on loss of lock, on any overflow flag or on acquisition timeout.
// - Sits beside tx_phase_aligner in the refclk domain; drives its rst input and reports status upward.
// PARAMETERS
// RST_CYCLES     64        refclk cycles picxo_rst is held high in RESET
// SETTLE_CYCLES  4096      refclk cycles waited after reset release before error sampling
// LOCK_THRESH    256       |error| <= LOCK_THRESH counts as a good sample
// UNLOCK_THRESH  1024      |error| >  UNLOCK_THRESH counts as a bad sample
// LOCK_COUNT     16        consecutive good samples needed to lock
// UNLOCK_COUNT   4         consecutive bad samples needed to drop lock
// ACQ_TIMEOUT    1048576   refclk cycles allowed in ACQUIRE before retry
// CNT_W          8         width of relock_count
// PORTS
// refclk        in   1      sole clock; all logic is in this domain
// rst           in   1      asynchronous, active-high reset
// txresetdone   in   1      GT TX reset done, already synchronised to refclk
// err_valid     in   1      one-cycle strobe: picxo_err is new (PICXO CE_DSP_O)
// picxo_err     in   21     signed PICXO phase error (ERROR_O)
// picxo_ovf     in   4      {OVF_PD, OVF_AB, OVF_VOLT, OVF_INT}; level-sensitive
// picxo_rst     out  1      reset to tx_phase_aligner, registered
// locked        out  1      aligner locked, registered
// relock_count  out  CNT_W  number of re-reset events since rst, saturating
// state_o       out  3      current state encoding, for debug/ILA
// BEHAVIOUR
// - Reset values: picxo_rst=1, locked=0, relock_count=0, state_o=IDLE, all internal counters 0.
// - States and encodings: IDLE=0, RESET=1, SETTLE=2, ACQUIRE=3, LOCKED=4.
// - Outputs are registered and change on the same edge as the state register.
// - picxo_rst=1 in IDLE and RESET, 0 otherwise. locked=1 only in LOCKED.
// - IDLE: leave to RESET on the first cycle txresetdone=1.
// - RESET: lasts exactly RST_CYCLES cycles, then SETTLE.
// - SETTLE: lasts exactly SETTLE_CYCLES cycles, then ACQUIRE. Ignores err_valid and picxo_ovf.
// - ACQUIRE:
//   - The timeout counter is cleared on entry.
//   - On each err_valid: |picxo_err| <= LOCK_THRESH increments good_cnt, otherwise good_cnt clears.
//   - good_cnt reaching LOCK_COUNT moves to LOCKED.
//   - The timeout counter reaching ACQ_TIMEOUT, or any picxo_ovf bit set, moves to RESET (retry).
// - LOCKED:
//   - On each err_valid: |picxo_err| > UNLOCK_THRESH increments bad_cnt, otherwise bad_cnt clears.
//   - bad_cnt reaching UNLOCK_COUNT moves to RESET (retry).
//   - Any picxo_ovf bit set moves to RESET (retry) on the next edge.
// - Retry: every ACQUIRE->RESET or LOCKED->RESET transition increments relock_count, saturating at 2^CNT_W-1.
// - |picxo_err| is computed as a 21-bit unsigned value; -2^20 maps to 2^20 (no overflow).
// - Thresholds are compared unsigned.
// - Priority, highest first:
//   1. txresetdone=0 in any non-IDLE state -> IDLE (no relock_count increment).
//   2. Overflow.
//   3. Lock reached. If lock is reached on the same cycle as the timeout, lock wins.
//   4. Timeout.
// - good_cnt and bad_cnt clear on every state entry. err_valid outside ACQUIRE/LOCKED is ignored.
// - rst asserted mid-operation: all outputs return to reset values immediately (asynchronous).
// - Latency: err_valid with the final qualifying sample -> locked=1 one cycle later.
// TESTING
// Bench overrides: RST_CYCLES=4, SETTLE_CYCLES=8, LOCK_COUNT=4, UNLOCK_COUNT=2, ACQ_TIMEOUT=100.
// 1. Normal lock:
//    - Stimulus: txresetdone=1 at cycle 10; after SETTLE, 4 err_valid strobes with err=+100.
//    - Required: picxo_rst high for exactly 4 cycles; locked=1 one cycle after the 4th strobe; relock_count=0.
// 2. Broken run:
//    - Stimulus: in ACQUIRE, errors 100, 100, 300, 100, 100, 100, 100.
//    - Required: lock only after the 7th strobe.
//    - Also: err=-1048576 counts as bad, not good.
// 3. Timeout:
//    - Stimulus: in ACQUIRE, no err_valid for 100 cycles.
//    - Required: state RESET; relock_count=1; picxo_rst=1 again for 4 cycles.
// 4. Loss of lock:
//    - Stimulus: in LOCKED, errors 2000, 500, 2000, 2000.
//    - Required: stays LOCKED after the 2nd strobe; goes to RESET after the 4th; relock_count increments.
// 5. Overflow:
//    - Stimulus: picxo_ovf=4'b0010 for 1 cycle while LOCKED -> RESET and locked=0 next edge.
//    - Stimulus: picxo_ovf set during SETTLE -> ignored.
//    - Stimulus: overflow and txresetdone=0 on the same cycle -> IDLE, relock_count unchanged.
// 6. Resets:
//    - Stimulus: drop txresetdone in SETTLE -> IDLE, picxo_rst=1.
//    - Stimulus: assert rst mid-ACQUIRE -> all outputs at reset values without waiting for a clock edge.
//    - Stimulus: force 300 retries -> relock_count holds at 255.

Source files
------------

// File: rtl/picxo_lock_sequencer.sv
// Startup and supervision FSM for the PICXO TX phase aligner.
// Holds PICXO in reset until the GT TX path is up, waits for the loop to
// settle, declares lock after a run of good error samples and re-resets
// PICXO on loss of lock, overflow or acquisition timeout.
module picxo_lock_sequencer #(
    parameter int RST_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 4096,
    parameter int LOCK_THRESH   = 256,
    parameter int UNLOCK_THRESH = 1024,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int ACQ_TIMEOUT   = 1048576,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             txresetdone,
    input  logic             err_valid,
    input  logic [20:0]      picxo_err,
    input  logic [3:0]       picxo_ovf,
    output logic             picxo_rst,
    output logic             locked,
    output logic [CNT_W-1:0] relock_count,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    // One shared cycle counter serves RESET, SETTLE and the ACQUIRE timeout,
    // so it is sized for the longest of the three.
    localparam int CYC_MAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CYC_MAX  = (CYC_MAX0 > ACQ_TIMEOUT) ? CYC_MAX0 : ACQ_TIMEOUT;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W    = $clog2(UNLOCK_COUNT + 1);

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic [CNT_W-1:0]   relock_q, relock_d;
    logic               picxo_rst_q;
    logic               locked_q;

    logic [20:0]        err_abs;
    logic               sample_good;
    logic               sample_bad;
    logic               ovf_any;

    // Magnitude as 21-bit unsigned: the most negative input maps to 2^20
    // without wrapping.
    assign err_abs     = picxo_err[20] ? (~picxo_err + 21'd1) : picxo_err;
    assign sample_good = (err_abs <= 21'(LOCK_THRESH));
    assign sample_bad  = (err_abs >  21'(UNLOCK_THRESH));
    assign ovf_any     = |picxo_ovf;

    // Next-state logic: per-state behaviour, then retry and txresetdone
    // overrides, then counter clearing on any state change.
    always_comb begin
        logic retry;
        state_d  = state_q;
        cyc_d    = cyc_q;
        good_d   = good_q;
        bad_d    = bad_q;
        relock_d = relock_q;
        retry    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (txresetdone) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (cyc_q == CYC_W'(RST_CYCLES - 1)) state_d = ST_SETTLE;
                else                                  cyc_d   = cyc_q + CYC_W'(1);
            end
            ST_SETTLE: begin
                if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) state_d = ST_ACQUIRE;
                else                                     cyc_d   = cyc_q + CYC_W'(1);
            end
            ST_ACQUIRE: begin
                if (ovf_any) begin
                    retry = 1'b1;
                end else if (err_valid && sample_good &&
                             good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                    // Lock beats a coincident timeout.
                    state_d = ST_LOCKED;
                end else if (cyc_q == CYC_W'(ACQ_TIMEOUT - 1)) begin
                    retry = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (err_valid) good_d = sample_good ? good_q + GOOD_W'(1) : '0;
                end
            end
            ST_LOCKED: begin
                if (ovf_any) begin
                    retry = 1'b1;
                end else if (err_valid) begin
                    if (!sample_bad)                          bad_d = '0;
                    else if (bad_q == BAD_W'(UNLOCK_COUNT - 1)) retry = 1'b1;
                    else                                      bad_d = bad_q + BAD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retry) begin
            state_d = ST_RESET;
            if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
        end

        // Losing the TX path overrides everything and is not a relock event.
        if (state_q != ST_IDLE && !txresetdone) begin
            state_d  = ST_IDLE;
            relock_d = relock_q;
        end

        if (state_d != state_q) begin
            cyc_d  = '0;
            good_d = '0;
            bad_d  = '0;
        end
    end

    // State, counters and registered outputs, all updated on the same edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            relock_q    <= '0;
            picxo_rst_q <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            relock_q    <= relock_d;
            picxo_rst_q <= (state_d == ST_IDLE) || (state_d == ST_RESET);
            locked_q    <= (state_d == ST_LOCKED);
        end
    end

    assign picxo_rst    = picxo_rst_q;
    assign locked       = locked_q;
    assign relock_count = relock_q;
    assign state_o      = state_q;

endmodule
